// File: rtl/cic_i2c_frame_sched_if.sv
// ---------------------------------------------------------------------------
// cic_i2c_frame_sched_if
// Bundles the two streaming paths of the frame scheduler:
//   sample_valid / sample_data : CIC decimator word strobe and data
//   frame_valid  / frame_data  : frame presented to the I2C slave transmitter
//   frame_ack    / frame_abort : per-frame completion / replay request
// Modports:
//   master : producer/consumer side (CIC + I2C slave, or a testbench)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface cic_i2c_frame_sched_if #(
   parameter int DATA_W = 48
);
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              frame_valid;
   logic [DATA_W-1:0] frame_data;
   logic              frame_ack;
   logic              frame_abort;

   modport master (
      output sample_valid, sample_data, frame_ack, frame_abort,
      input  frame_valid, frame_data
   );

   modport slave (
      input  sample_valid, sample_data, frame_ack, frame_abort,
      output frame_valid, frame_data
   );
endinterface

// File: rtl/cic_i2c_frame_sched.sv
// ---------------------------------------------------------------------------
// cic_i2c_frame_sched
// Buffers 48-bit CIC words in a DEPTH-entry FIFO and presents one frame at a
// time to the I2C slave. A frame is retired only by frame_ack; frame_abort
// leaves the presented frame in place so the transfer is replayed. Acked
// frames are counted per MCU read block, and drdy tells the MCU data exists.
// Ports:
//   sys_clk, reset  : clock, asynchronous active-high reset
//   enable          : 0 flushes the FIFO and holds the scheduler idle
//   clr_status      : pulse, clears overflow / overflow_cnt
//   bus (slave)     : sample input stream and frame presentation handshake
//   drdy            : registered occupancy >= DRDY_THRESH
//   fill_level      : FIFO entries, excluding the presented frame
//   block_cnt       : acked frames in the current block
//   block_done      : one-cycle pulse after the block-wrapping ack
//   overflow        : sticky, a sample was dropped
//   overflow_cnt    : dropped samples, saturating at 255
// ---------------------------------------------------------------------------
module cic_i2c_frame_sched #(
   parameter  int DEPTH        = 4,
   parameter  int BLOCK_FRAMES = 36,
   parameter  int DRDY_THRESH  = 1,
   localparam int AW           = $clog2(DEPTH),
   localparam int BW           = (BLOCK_FRAMES > 1) ? $clog2(BLOCK_FRAMES) : 1
) (
   input  logic                      sys_clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      clr_status,
   cic_i2c_frame_sched_if.slave      bus,
   output logic                      drdy,
   output logic [AW:0]               fill_level,
   output logic [BW-1:0]             block_cnt,
   output logic                      block_done,
   output logic                      overflow,
   output logic [7:0]                overflow_cnt
);

   localparam int DATA_W = 48;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PRESENT = 1'b1;

   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW+1:0] THRESH_C = (AW+2)'(DRDY_THRESH);
   localparam logic [BW-1:0] LAST_C   = BW'(BLOCK_FRAMES - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] frame_data_q, frame_data_d;
   logic [BW-1:0]     block_cnt_q, block_cnt_d;
   logic              block_done_q, block_done_d;
   logic              drdy_q, drdy_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        ovf_cnt_q, ovf_cnt_d;

   logic              full, pop, wr, drop, ack_eff;
   logic [AW+1:0]     occ_d;

   always_comb begin
      full    = (cnt_q == DEPTH_C);
      pop     = 1'b0;
      ack_eff = 1'b0;
      if (enable) begin
         if (state_q == S_IDLE) begin
            pop = (cnt_q != '0);
         end else begin
            // Ack wins over a simultaneous abort; an ack in IDLE is ignored.
            ack_eff = bus.frame_ack;
            pop     = bus.frame_ack && (cnt_q != '0);
         end
      end
      // A same-cycle pop frees the slot, so a write at full is still accepted.
      wr   = enable && bus.sample_valid && (!full || pop);
      drop = enable && bus.sample_valid && full && !pop;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      state_d      = state_q;
      frame_data_d = frame_data_q;
      block_cnt_d  = block_cnt_q;
      block_done_d = 1'b0;

      if (!enable) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         cnt_d        = '0;
         state_d      = S_IDLE;
         frame_data_d = '0;
         block_cnt_d  = '0;
      end else begin
         if (wr)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            frame_data_d = mem_q[rd_ptr_q];
         end
         case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase

         case (state_q)
            S_IDLE: begin
               if (pop) state_d = S_PRESENT;
            end
            default: begin
               if (bus.frame_ack) begin
                  state_d = pop ? S_PRESENT : S_IDLE;
               end else if (bus.frame_abort) begin
                  // Replay: keep presenting the same frame untouched.
                  state_d = S_PRESENT;
               end
            end
         endcase

         if (ack_eff) begin
            if (block_cnt_q == LAST_C) begin
               block_cnt_d  = '0;
               block_done_d = 1'b1;
            end else begin
               block_cnt_d = block_cnt_q + 1'b1;
            end
         end
      end

      // Occupancy counts the presentation register as one more entry.
      occ_d  = {1'b0, cnt_d} + {{(AW+1){1'b0}}, (state_d == S_PRESENT)};
      drdy_d = (occ_d >= THRESH_C);
   end

   // Status: a drop in the same cycle as clr_status leaves a count of one.
   always_comb begin
      overflow_d = overflow_q;
      ovf_cnt_d  = ovf_cnt_q;
      if (drop) begin
         overflow_d = 1'b1;
         ovf_cnt_d  = clr_status ? 8'd1 : sat_inc8(ovf_cnt_q);
      end else if (clr_status) begin
         overflow_d = 1'b0;
         ovf_cnt_d  = 8'd0;
      end
   end

   // FIFO storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge sys_clk) begin
      if (wr) mem_q[wr_ptr_q] <= bus.sample_data;
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         state_q      <= S_IDLE;
         frame_data_q <= '0;
         block_cnt_q  <= '0;
         block_done_q <= 1'b0;
         drdy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         ovf_cnt_q    <= 8'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         frame_data_q <= frame_data_d;
         block_cnt_q  <= block_cnt_d;
         block_done_q <= block_done_d;
         drdy_q       <= drdy_d;
         overflow_q   <= overflow_d;
         ovf_cnt_q    <= ovf_cnt_d;
      end
   end

   assign bus.frame_valid = (state_q == S_PRESENT);
   assign bus.frame_data  = frame_data_q;
   assign drdy            = drdy_q;
   assign fill_level      = cnt_q;
   assign block_cnt       = block_cnt_q;
   assign block_done      = block_done_q;
   assign overflow        = overflow_q;
   assign overflow_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_cic_i2c_frame_sched.sv
module tb_cic_i2c_frame_sched;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        clr_status;
   logic        drdy;
   logic [2:0]  fill_level;
   logic [5:0]  block_cnt;
   logic        block_done;
   logic        overflow;
   logic [7:0]  overflow_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int done_pulses = 0;

   cic_i2c_frame_sched_if #(.DATA_W(48)) bus ();

   cic_i2c_frame_sched #(
      .DEPTH(4), .BLOCK_FRAMES(36), .DRDY_THRESH(1)
   ) dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .enable       (enable),
      .clr_status   (clr_status),
      .bus          (bus),
      .drdy         (drdy),
      .fill_level   (fill_level),
      .block_cnt    (block_cnt),
      .block_done   (block_done),
      .overflow     (overflow),
      .overflow_cnt (overflow_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) if (block_done === 1'b1) done_pulses++;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [47:0] d);
      bus.sample_valid = 1'b1;
      bus.sample_data  = d;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic ack();
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag, input logic [7:0] ovf_cnt_exp);
      check({tag, "_valid"}, 64'(bus.frame_valid), 64'd0);
      check({tag, "_data"},  64'(bus.frame_data),  64'd0);
      check({tag, "_drdy"},  64'(drdy),            64'd0);
      check({tag, "_fill"},  64'(fill_level),      64'd0);
      check({tag, "_blk"},   64'(block_cnt),       64'd0);
      check({tag, "_done"},  64'(block_done),      64'd0);
      check({tag, "_ovf"},   64'(overflow),        64'(ovf_cnt_exp != 0));
      check({tag, "_ovfc"},  64'(overflow_cnt),    64'(ovf_cnt_exp));
   endtask

   initial begin
      int d0;
      reset            = 1'b1;
      enable           = 1'b1;
      clr_status       = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.frame_ack    = 1'b0;
      bus.frame_abort  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_reset_vals("rst", 8'd0);

      // Single sample: presented two cycles later, then acked.
      send(48'h0605_0403_0201);
      check("t1_fill_k1",  64'(fill_level),      64'd1);
      check("t1_valid_k1", 64'(bus.frame_valid), 64'd0);
      tick();
      check("t1_valid_k2", 64'(bus.frame_valid), 64'd1);
      check("t1_data_k2",  64'(bus.frame_data),  64'h0605_0403_0201);
      check("t1_drdy_k2",  64'(drdy),            64'd1);
      check("t1_fill_k2",  64'(fill_level),      64'd0);
      ack();
      check("t1_valid_ack", 64'(bus.frame_valid), 64'd0);
      check("t1_drdy_ack",  64'(drdy),            64'd0);
      check("t1_blk_ack",   64'(block_cnt),       64'd1);

      // Five samples without ack fill FIFO plus presentation register.
      for (int i = 1; i <= 5; i++) send(48'hA0_0000_0000 + 48'(i));
      check("t2_fill",  64'(fill_level),      64'd4);
      check("t2_valid", 64'(bus.frame_valid), 64'd1);
      check("t2_data",  64'(bus.frame_data),  64'hA0_0000_0001);
      check("t2_ovf0",  64'(overflow),        64'd0);
      send(48'hA0_0000_0006);
      check("t2_ovf1",  64'(overflow),        64'd1);
      check("t2_ovfc1", 64'(overflow_cnt),    64'd1);
      check("t2_fill6", 64'(fill_level),      64'd4);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("t2_ovf_clr",  64'(overflow),     64'd0);
      check("t2_ovfc_clr", 64'(overflow_cnt), 64'd0);

      // Abort replays frame A; ack then brings frame B a cycle later.
      bus.frame_abort = 1'b1;
      tick();
      bus.frame_abort = 1'b0;
      check("t3_abort_data",  64'(bus.frame_data),  64'hA0_0000_0001);
      check("t3_abort_valid", 64'(bus.frame_valid), 64'd1);
      check("t3_abort_blk",   64'(block_cnt),       64'd1);
      check("t3_abort_fill",  64'(fill_level),      64'd4);
      ack();
      check("t3_ack_data", 64'(bus.frame_data), 64'hA0_0000_0002);
      check("t3_ack_blk",  64'(block_cnt),      64'd2);
      check("t3_ack_fill", 64'(fill_level),     64'd3);

      // Refill to full, then ack+abort together with a write at full.
      send(48'hA0_0000_0007);
      check("t5_fill_full", 64'(fill_level), 64'd4);
      bus.frame_ack    = 1'b1;
      bus.frame_abort  = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample_data  = 48'hA0_0000_0008;
      tick();
      bus.frame_ack    = 1'b0;
      bus.frame_abort  = 1'b0;
      bus.sample_valid = 1'b0;
      check("t5_data", 64'(bus.frame_data), 64'hA0_0000_0003);
      check("t5_fill", 64'(fill_level),     64'd4);
      check("t5_ovf",  64'(overflow),       64'd0);
      check("t5_blk",  64'(block_cnt),      64'd3);

      // Drop one to make overflow nonzero, ack to fill_level=3, then reset.
      send(48'hA0_0000_0009);
      check("t6_ovf_pre", 64'(overflow), 64'd1);
      ack();
      check("t6_fill_pre", 64'(fill_level),     64'd3);
      check("t6_data_pre", 64'(bus.frame_data), 64'hA0_0000_0004);
      #2 reset = 1'b1;
      #1 check_reset_vals("t6_arst", 8'd0);
      #1 reset = 1'b0;
      tick();

      // enable=0 mid-PRESENT: everything cleared except overflow status.
      for (int i = 1; i <= 6; i++) send(48'hB0_0000_0000 + 48'(i));
      check("t7_ovfc_pre", 64'(overflow_cnt), 64'd1);
      ack();
      check("t7_blk_pre",  64'(block_cnt),      64'd1);
      check("t7_data_pre", 64'(bus.frame_data), 64'hB0_0000_0002);
      enable           = 1'b0;
      bus.sample_valid = 1'b1;
      bus.sample_data  = 48'hB0_0000_00FF;
      tick();
      check_reset_vals("t7_dis", 8'd1);
      tick();
      check("t7_dis_ovfc2", 64'(overflow_cnt), 64'd1);
      check("t7_dis_fill2", 64'(fill_level),   64'd0);
      bus.sample_valid = 1'b0;
      enable           = 1'b1;
      tick();

      // 36 write/ack pairs: block counter wraps once with one done pulse.
      d0 = done_pulses;
      for (int i = 0; i < 36; i++) begin
         send(48'hC0_0000_0000 + 48'(i));
         tick();
         check($sformatf("t4_valid_%0d", i), 64'(bus.frame_valid), 64'd1);
         check($sformatf("t4_blk_%0d", i),   64'(block_cnt),       64'(i));
         ack();
         check($sformatf("t4_done_%0d", i),  64'(block_done),      64'(i == 35));
         check($sformatf("t4_blkn_%0d", i),  64'(block_cnt),       64'((i + 1) % 36));
      end
      tick();
      check("t4_done_after", 64'(block_done),        64'd0);
      check("t4_done_count", 64'(done_pulses - d0),  64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
